// File: rtl/flash_pkg.sv
// Opcodes, FSM encodings and SPI frame timing shared by the SPI flash controllers.
// FLASH_PP_TPP_WAIT_EN adds the post-program wait state to the state enum.
package flash_pkg;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_BE   = 8'hC7;
  localparam logic [7:0] OP_RDSR = 8'h05;

  localparam int SCK_DIV   = 4;
  localparam int SETUP_CYC = 4;
  localparam int HOLD_CYC  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREN,
    S_GAP,
    S_PP,
`ifdef FLASH_PP_TPP_WAIT_EN
    S_WAIT,
`endif
    S_DONE
  } state_t;

  // Position inside a chip-select frame; ST_TAIL is the one cs_n-high cycle after PP.
  typedef enum logic [1:0] {
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_TAIL
  } stage_t;

endpackage

// File: rtl/spi_byte_tx.sv
// Shifts one byte out MSB first in SPI mode 0 over 8 x SCK_DIV cycles.
// A start during the last_phase cycle chains the next byte with no idle cycle.
module spi_byte_tx
  import flash_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din,
  output logic       sck,
  output logic       mosi,
  output logic       last_phase
);

  localparam logic [1:0] PH_LAST = 2'(SCK_DIV - 1);
  localparam logic [1:0] PH_HIGH = 2'(SCK_DIV / 2);

  logic [1:0] ph;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       active;

  assign last_phase = active && (ph == PH_LAST) && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      ph      <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      ph      <= '0;
      bit_cnt <= '0;
      shreg   <= din;
      sck     <= 1'b0;
      mosi    <= din[7];
    end else if (active) begin
      ph  <= ph + 2'd1;
      // sck reflects the phase of the coming cycle: low in the first half, high in the second
      sck <= (ph != PH_LAST) && ((ph + 2'd1) >= PH_HIGH);
      if (ph == PH_LAST) begin
        if (bit_cnt == 3'd7) begin
          active <= 1'b0;
          mosi   <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          mosi    <= shreg[6];
          shreg   <= {shreg[6:0], shreg[7]};
        end
      end
    end
  end

endmodule

// File: rtl/flash_pp_ctrl.sv
// SPI flash page-program sequencer: WREN frame, cs_n gap, PP frame (opcode, 24-bit address, data).
// Define FLASH_PP_TPP_WAIT_EN to keep busy high for TPP_CYC cycles after the PP frame.
module flash_pp_ctrl
  import flash_pkg::*;
#(
  parameter logic [23:0] PAGE_ADDR = 24'h00_04_25,
  parameter int          DATA_NUM  = 10,
  parameter logic [7:0]  DATA_INIT = 8'h00,
  parameter int          CS_GAP    = 32,
  parameter int          TPP_CYC   = 150000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key,
  output logic sck,
  output logic cs_n,
  output logic mosi,
  output logic busy,
  output logic done
);

  localparam int CNT_TOP = (CS_GAP > TPP_CYC) ? CS_GAP : TPP_CYC;
  localparam int CNT_MIN = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int CW      = $clog2(((CNT_TOP > CNT_MIN) ? CNT_TOP : CNT_MIN) + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
`ifdef FLASH_PP_TPP_WAIT_EN
  localparam logic [CW-1:0] TPP_LAST   = CW'(TPP_CYC - 1);
`endif
  localparam logic [8:0]    PP_BYTES   = 9'(4 + DATA_NUM);

  state_t        state, state_nxt;
  stage_t        stage, stage_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [8:0]    byte_cnt, byte_cnt_nxt;
  logic [8:0]    frame_bytes;
  logic          tx_start;
  logic          tx_last;
  logic [7:0]    tx_byte;

  spi_byte_tx u_tx (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .start      (tx_start),
    .din        (tx_byte),
    .sck        (sck),
    .mosi       (mosi),
    .last_phase (tx_last)
  );

  // byte_cnt holds the index of the next byte to hand to the shifter
  always_comb begin
    tx_byte = DATA_INIT + 8'(byte_cnt - 9'd4);
    if (state == S_WREN)        tx_byte = OP_WREN;
    else if (byte_cnt == 9'd0)  tx_byte = OP_PP;
    else if (byte_cnt == 9'd1)  tx_byte = PAGE_ADDR[23:16];
    else if (byte_cnt == 9'd2)  tx_byte = PAGE_ADDR[15:8];
    else if (byte_cnt == 9'd3)  tx_byte = PAGE_ADDR[7:0];
    frame_bytes = (state == S_WREN) ? 9'd1 : PP_BYTES;
  end

  always_comb begin
    state_nxt    = state;
    stage_nxt    = stage;
    cnt_nxt      = cnt;
    byte_cnt_nxt = byte_cnt;
    tx_start     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (key) begin
          state_nxt    = S_WREN;
          stage_nxt    = ST_SETUP;
          cnt_nxt      = '0;
          byte_cnt_nxt = '0;
        end
      end
      S_WREN, S_PP: begin
        case (stage)
          ST_SETUP: begin
            if (cnt == SETUP_LAST) begin
              tx_start     = 1'b1;
              byte_cnt_nxt = byte_cnt + 9'd1;
              stage_nxt    = ST_SHIFT;
              cnt_nxt      = '0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
          ST_SHIFT: begin
            if (tx_last) begin
              if (byte_cnt == frame_bytes) begin
                stage_nxt = ST_HOLD;
              end else begin
                tx_start     = 1'b1;
                byte_cnt_nxt = byte_cnt + 9'd1;
              end
            end
          end
          ST_HOLD: begin
            if (cnt == HOLD_LAST) begin
              cnt_nxt = '0;
              if (state == S_WREN) state_nxt = S_GAP;
              else                 stage_nxt = ST_TAIL;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
          default: begin
`ifdef FLASH_PP_TPP_WAIT_EN
            state_nxt = S_WAIT;
            cnt_nxt   = '0;
`else
            state_nxt = S_DONE;
`endif
          end
        endcase
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt    = S_PP;
          stage_nxt    = ST_SETUP;
          cnt_nxt      = '0;
          byte_cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`ifdef FLASH_PP_TPP_WAIT_EN
      S_WAIT: begin
        if (cnt == TPP_LAST) state_nxt = S_DONE;
        else                 cnt_nxt   = cnt + 1'b1;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state they describe
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      stage    <= ST_SETUP;
      cnt      <= '0;
      byte_cnt <= '0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      stage    <= stage_nxt;
      cnt      <= cnt_nxt;
      byte_cnt <= byte_cnt_nxt;
      cs_n     <= !((state_nxt == S_WREN) || ((state_nxt == S_PP) && (stage_nxt != ST_TAIL)));
      busy     <= !((state_nxt == S_IDLE) || (state_nxt == S_DONE));
      done     <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_flash_pp_ctrl.sv
// Bench for flash_pp_ctrl: reset table, transaction-level reference model, frame decoding.
module tb_flash_pp_ctrl;

  localparam int         TPP = 100;
  localparam logic [4:0] IDLE_T = 5'b10000;  // {cs_n, sck, mosi, busy, done}
`ifdef FLASH_PP_TPP_WAIT_EN
  localparam int TAIL = TPP + 1;
`else
  localparam int TAIL = 1;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct packed { logic rst; logic k; logic [4:0] want; } vec_t;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       key_v [3];
  logic [4:0] obs [3];
  logic       sck0, cs0, mosi0, busy0, done0;
  logic       sck1, cs1, mosi1, busy1, done1;
  logic       sck2, cs2, mosi2, busy2, done2;

  int         num_a  [3] = '{10, 1, 256};
  logic [7:0] init_a [3] = '{8'h00, 8'h00, 8'hFE};
  int         gap_a  [3] = '{32, 32, 1};

  int         vectors = 0;
  int         miscompares = 0;
  logic [4:0] mq[$];
  logic [4:0] mcur = IDLE_T;
  logic [4:0] cap[$];
  logic [4:0] gold[$];
  vec_t       tbl [14];

  flash_pp_ctrl #(.TPP_CYC(TPP)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key_v[0]),
    .sck(sck0), .cs_n(cs0), .mosi(mosi0), .busy(busy0), .done(done0));
  flash_pp_ctrl #(.DATA_NUM(1), .TPP_CYC(TPP)) dut_one (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key_v[1]),
    .sck(sck1), .cs_n(cs1), .mosi(mosi1), .busy(busy1), .done(done1));
  flash_pp_ctrl #(.DATA_NUM(256), .DATA_INIT(8'hFE), .CS_GAP(1), .TPP_CYC(TPP)) dut_big (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key_v[2]),
    .sck(sck2), .cs_n(cs2), .mosi(mosi2), .busy(busy2), .done(done2));

  assign obs[0] = {cs0, sck0, mosi0, busy0, done0};
  assign obs[1] = {cs1, sck1, mosi1, busy1, done1};
  assign obs[2] = {cs2, sck2, mosi2, busy2, done2};

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic pp_bytes(input int idx, output bq_t b);
    b = {8'h02, 8'h00, 8'h04, 8'h25};
    for (int k = 0; k < num_a[idx]; k++) b.push_back(8'(init_a[idx] + 8'(k)));
  endtask

  task automatic push_frame(input bq_t b);
    repeat (4) mq.push_back(5'b00010);
    foreach (b[i])
      for (int k = 7; k >= 0; k--) begin
        repeat (2) mq.push_back({2'b00, b[i][k], 2'b10});
        repeat (2) mq.push_back({2'b01, b[i][k], 2'b10});
      end
    repeat (4) mq.push_back(5'b00010);
  endtask

  // Expected output sequence of one whole program operation, cycle by cycle after the key edge
  task automatic push_trace(input int idx);
    bq_t b;
    push_frame('{8'h06});
    repeat (gap_a[idx]) mq.push_back(5'b10010);
    pp_bytes(idx, b);
    push_frame(b);
    repeat (TAIL) mq.push_back(5'b10010);
    mq.push_back(5'b10001);
  endtask

  task automatic step(input int idx, input logic k);
    key_v[idx] = k;
    @(posedge sys_clk);
    if (!sys_rst_n) begin
      mq.delete();
      mcur = IDLE_T;
    end else begin
      if (k && !mcur[1]) begin
        mq.delete();
        push_trace(idx);
      end
      mcur = (mq.size() > 0) ? mq.pop_front() : IDLE_T;
    end
    #1;
    key_v[idx] = 1'b0;
    cap.push_back(obs[idx]);
    chk($sformatf("cycle_dut%0d", idx), obs[idx], mcur);
  endtask

  task automatic pulse_reset(input int idx);
    sys_rst_n = 1'b0;
    #1;
    chk("rst_async", obs[idx], IDLE_T);
    step(idx, 1'b0);
    sys_rst_n = 1'b1;
  endtask

  task automatic run_body(input int idx, input int kc1, input int kc2, input int rst_at);
    for (int c = 0; c < 9000; c++) begin
      if (mcur[0]) return;
      if (c == rst_at) begin
        pulse_reset(idx);
        return;
      end
      step(idx, (c == kc1) || (c == kc2));
    end
  endtask

  // Decodes the captured pins: cs_n low runs, gap, bytes on sck rising edges, done pulses
  task automatic analyze(input string nm, input int idx);
    int runs[$];
    bq_t got, want;
    int low = 0, hi = 0, gap = -1, dn = 0, dly = -1, nb = 0, bad;
    logic [7:0] sh = 8'h00;
    logic ps = 1'b0;
    foreach (cap[i]) begin
      if (!cap[i][4]) begin
        if (runs.size() == 1 && low == 0) gap = hi;
        low++;
        hi = 0;
        if (cap[i][3] && !ps) begin
          sh = {sh[6:0], cap[i][2]};
          nb++;
          if (nb == 8) begin got.push_back(sh); nb = 0; end
        end
      end else begin
        if (low > 0) begin runs.push_back(low); low = 0; end
        hi++;
        if (cap[i][0]) begin dn++; dly = hi - 1; end
      end
      ps = cap[i][3];
    end
    pp_bytes(idx, want);
    want.push_front(8'h06);
    bad = (got.size() != want.size()) ? 1 : 0;
    if (bad == 0) foreach (got[i]) if (got[i] != want[i]) bad++;
    chk({nm, "_frames"}, runs.size(), 2);
    chk({nm, "_wren_len"}, (runs.size() > 0) ? runs[0] : -1, 40);
    chk({nm, "_pp_len"}, (runs.size() > 1) ? runs[1] : -1, 8 + 32 * (4 + num_a[idx]));
    chk({nm, "_gap"}, gap, gap_a[idx]);
    chk({nm, "_bytes_bad"}, bad, 0);
    chk({nm, "_done_cnt"}, dn, 1);
    chk({nm, "_done_dly"}, dly, TAIL);
  endtask

  task automatic cmp_gold(input string nm);
    int bad = (cap.size() != gold.size()) ? 1 : 0;
    if (bad == 0) foreach (cap[i]) if (cap[i] != gold[i]) bad++;
    chk(nm, bad, 0);
  endtask

  task automatic txn(input int idx, input int kc1, input int kc2, input int rst_at);
    cap.delete();
    step(idx, 1'b1);
    run_body(idx, kc1, kc2, rst_at);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) key_v[i] = 1'b0;
    tbl[0]  = '{1'b0, 1'b0, 5'b10000};
    tbl[1]  = '{1'b1, 1'b0, 5'b10000};
    tbl[2]  = '{1'b1, 1'b1, 5'b00010};
    tbl[3]  = '{1'b1, 1'b0, 5'b00010};
    tbl[4]  = '{1'b1, 1'b0, 5'b00010};
    tbl[5]  = '{1'b1, 1'b0, 5'b00010};
    tbl[6]  = '{1'b1, 1'b0, 5'b00010};
    tbl[7]  = '{1'b1, 1'b0, 5'b00010};
    tbl[8]  = '{1'b1, 1'b0, 5'b01010};
    tbl[9]  = '{1'b1, 1'b0, 5'b01010};
    tbl[10] = '{1'b1, 1'b0, 5'b00010};
    tbl[11] = '{1'b1, 1'b1, 5'b00010};
    tbl[12] = '{1'b1, 1'b0, 5'b01010};
    tbl[13] = '{1'b1, 1'b0, 5'b01010};
    repeat (2) @(posedge sys_clk);
    #1;
    for (int i = 0; i < 14; i++) begin
      sys_rst_n = tbl[i].rst;
      key_v[0]  = tbl[i].k;
      @(posedge sys_clk);
      #1;
      key_v[0] = 1'b0;
      chk($sformatf("tbl%0d", i), obs[0], tbl[i].want);
    end
    pulse_reset(0);
    repeat (3) step(0, 1'b0);

    txn(0, -1, -1, -1);
    analyze("single", 0);
    gold = cap;
    repeat (5) step(0, 1'b0);

    txn(0, 42, 171, -1);
    analyze("busy_keys", 0);
    cmp_gold("busy_keys_same");
    repeat (5) step(0, 1'b0);

    txn(0, -1, -1, 240);
    repeat (3) step(0, 1'b0);
    txn(0, -1, -1, -1);
    analyze("after_rst", 0);
    cmp_gold("after_rst_same");

    step(0, 1'b1);
    chk("key_in_done_csn", obs[0][4], 0);
    cap.delete();
    cap.push_back(obs[0]);
    run_body(0, -1, -1, -1);
    analyze("chained", 0);
    repeat (3) step(0, 1'b0);

    txn(1, -1, -1, -1);
    analyze("num1", 1);
    repeat (3) step(1, 1'b0);
    txn(2, -1, -1, -1);
    analyze("num256", 2);
    repeat (3) step(2, 1'b0);

    for (int i = 0; i < 6000; i++) begin
      int r = $urandom_range(0, 999);
      if (r < 2) pulse_reset(0);
      else       step(0, r < 40);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
